// File: rtl/vec_recorder.sv
// Records {s, d[0..3], y} samples into a small memory and dumps them on a registered stream.
// Optional VEC_RECORDER_DEDUP_EN: a capture equal to the last stored record is skipped.
module vec_recorder #(
    parameter int DEPTH = 64,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         cap_en,
    input  logic [1:0]   s,
    input  logic [3:0]   d,
    input  logic         y,
    input  logic         rd_req,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         rd_last,
    output logic [6:0]   count,
    output logic         full,
    output logic         busy
);
    // Dump handshake: a record transfers on any edge where rd_valid && rd_ready;
    // while rd_valid is high and rd_ready low, rd_data/rd_last/rd_valid hold.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, REC, FULL, DUMP} state_t;

    state_t       state_q;
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  wr_ptr_d;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rec;
    logic         dup;
    logic         wr_en;

    assign rec = {s, d[0], d[1], d[2], d[3], y};

`ifdef VEC_RECORDER_DEDUP_EN
    logic [AW-1:0] last_idx;
    assign last_idx = AW'(wr_ptr_q - ONE);
    assign dup      = (wr_ptr_q != '0) && (mem[last_idx] == rec);
`else
    assign dup = 1'b0;
`endif

    assign wr_en    = rst && (state_q == REC) && cap_en && !dup;
    assign wr_ptr_d = wr_ptr_q + ONE;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= rec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= REC;
                        wr_ptr_q <= '0;
                    end else if (rd_req && wr_ptr_q != '0) begin
                        state_q  <= DUMP;
                        rd_data  <= mem[0];
                        rd_valid <= 1'b1;
                        rd_last  <= (wr_ptr_q == ONE);
                        rd_ptr_q <= ONE;
                    end
                end
                REC: begin
                    if (wr_en) wr_ptr_q <= wr_ptr_d;
                    // stop ends the session even if this capture filled memory
                    if (stop) state_q <= IDLE;
                    else if (wr_en && wr_ptr_d == FULL_CNT) state_q <= FULL;
                end
                FULL: begin
                    if (start) begin
                        state_q  <= REC;
                        wr_ptr_q <= '0;
                    end else if (rd_req) begin
                        state_q  <= DUMP;
                        rd_data  <= mem[0];
                        rd_valid <= 1'b1;
                        rd_last  <= (wr_ptr_q == ONE);
                        rd_ptr_q <= ONE;
                    end
                end
                DUMP: begin
                    if (rd_valid && rd_ready) begin
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            rd_data  <= mem[rd_ptr_q[AW-1:0]];
                            rd_last  <= (rd_ptr_q == wr_ptr_q - ONE);
                            rd_ptr_q <= rd_ptr_q + ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count = 7'(wr_ptr_q);
    assign full  = (wr_ptr_q == FULL_CNT);
    assign busy  = (state_q == REC) || (state_q == DUMP);

endmodule

// File: tb/tb_vec_recorder.sv
// Directed bench for vec_recorder: capture sessions, full-memory drop, stalled dumps,
// mid-dump reset and the optional duplicate-skip build (VEC_RECORDER_DEDUP_EN).
module tb_vec_recorder;
    logic       clk = 1'b0;
    logic       rst, start, stop, cap_en, y, rd_req, rd_ready;
    logic [1:0] s;
    logic [3:0] d;
    logic [6:0] rd_data;
    logic       rd_valid, rd_last;
    logic [6:0] count;
    logic       full, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    vec_recorder dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cap_en(cap_en),
        .s(s), .d(d), .y(y), .rd_req(rd_req), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .count(count), .full(full), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] pack(input logic [1:0] ss, input logic [3:0] dd, input logic yy);
        return {ss, dd[0], dd[1], dd[2], dd[3], yy};
    endfunction

    // advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [1:0] ss, input logic [3:0] dd, input logic yy, input logic with_stop);
        s = ss; d = dd; y = yy; cap_en = 1'b1; stop = with_stop;
        step();
        cap_en = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    // dumps n records against exp_q; with stall, every 4th record sees rd_ready 0,0 before 1
    task automatic dump_check(input int n, input bit stall);
        logic [6:0] exp;
        rd_ready = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp = exp_q.pop_front();
            check("dump_valid", rd_valid, 1);
            check("dump_data", rd_data, exp);
            check("dump_last", rd_last, (i == n - 1));
            if (stall && (i % 4 == 0)) begin
                step();
                check("hold_valid", rd_valid, 1);
                check("hold_data", rd_data, exp);
                step();
                check("hold_data2", rd_data, exp);
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        check("dump_end_valid", rd_valid, 0);
        check("dump_end_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; cap_en = 1'b0; y = 1'b0;
        rd_req = 1'b0; rd_ready = 1'b0; s = '0; d = '0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_last", rd_last, 0);
        check("rst_data", rd_data, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        step();

        // dump request with nothing stored is ignored
        rd_req = 1'b1; step(); rd_req = 1'b0;
        check("empty_req_busy", busy, 0);
        check("empty_req_valid", rd_valid, 0);

        // three hand-packed records
        pulse_start();
        check("start_busy", busy, 1);
        check("start_count", count, 0);
        cap(2'd0, 4'b0001, 1'b1, 1'b0);
        cap(2'd2, 4'b0100, 1'b1, 1'b0);
        cap(2'd3, 4'b1000, 1'b0, 1'b0);
        check("three_count", count, 3);
        pulse_stop();
        check("stop_busy", busy, 0);
        exp_q.push_back(7'b0010001);
        exp_q.push_back(7'b1000101);
        exp_q.push_back(7'b1100010);
        dump_check(3, 1'b0);
        check("retain_count", count, 3);

        // capture while idle is ignored
        cap(2'd1, 4'b1111, 1'b1, 1'b0);
        check("idle_cap_count", count, 3);

        // fill memory, then overflow by six
        pulse_start();
        for (int i = 0; i < 70; i++) begin
            logic [6:0] v;
            v = 7'(i);
            cap(v[1:0], v[5:2], v[6] ^ v[0], 1'b0);
            if (i < 64) exp_q.push_back(pack(v[1:0], v[5:2], v[6] ^ v[0]));
            if (i == 62) check("full_at_63", full, 0);
            if (i == 63) begin
                check("full_at_64", full, 1);
                check("full_busy", busy, 0);
            end
        end
        check("overflow_count", count, 64);
        check("overflow_full", full, 1);
        dump_check(64, 1'b1);
        check("after_dump_count", count, 64);

        // restart from a full memory clears the count
        pulse_start();
        check("restart_count", count, 0);
        check("restart_full", full, 0);
        check("restart_busy", busy, 1);

        // capture with stop in the same cycle
        cap(2'd2, 4'b0011, 1'b0, 1'b0);
        cap(2'd0, 4'b1010, 1'b1, 1'b0);
        cap(2'd1, 4'b1111, 1'b1, 1'b1);
        check("capstop_count", count, 3);
        check("capstop_busy", busy, 0);
        exp_q.push_back(7'b1011000);
        exp_q.push_back(7'b0001011);
        exp_q.push_back(7'b0111111);
        dump_check(3, 1'b0);

        // reset in the middle of a dump
        pulse_start();
        for (int i = 0; i < 5; i++) cap(2'(i), 4'(i + 3), 1'b0, 1'b0);
        pulse_stop();
        check("five_count", count, 5);
        rd_req = 1'b1; step(); rd_req = 1'b0;
        rd_ready = 1'b1; step(); step();
        rd_ready = 1'b0;
        check("mid_dump_valid", rd_valid, 1);
        rst = 1'b0; step(); rst = 1'b1;
        check("abort_valid", rd_valid, 0);
        check("abort_count", count, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        step();

        // repeated identical capture
        pulse_start();
        for (int i = 0; i < 4; i++) cap(2'd1, 4'b0110, 1'b1, 1'b0);
`ifdef VEC_RECORDER_DEDUP_EN
        check("dup_count", count, 1);
`else
        check("dup_count", count, 4);
`endif
        pulse_stop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
